mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage directly downstream of the execute/ALU stage.
- Consumes the ALU result (as data or effective address), the PC and the store operand.
- Non-memory ops: passes the ALU result through to writeback.
- Loads/stores: runs a req/gnt/rvalid handshake to data memory, and aligns and extends load data. Stalls upstream via m_ready while an access is in flight.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, reset value of wb_pc.

Ports:
- clock  in  1  stage clock, posedge.
- reset  in  1  synchronous, active-high.
- m_valid  in  1  execute stage presents an instruction.
- m_pc  in  XLEN  PC of that instruction.
- is_load  in  1  instruction is a load.
- is_store  in  1  instruction is a store.
- funct3  in  3  RV32I size/sign field.
- alu_result  in  XLEN  ALU result / effective address.
- store_data  in  XLEN  rs2 value for stores.
- rd_in  in  5  destination register.
- m_ready  out  1  stage can accept this cycle.
- wb_valid  out  1  one-cycle pulse, result complete.
- wb_pc  out  XLEN  PC of completed instruction.
- wb_rd  out  5  destination (0 for stores).
- wb_data  out  XLEN  writeback value.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1=write.
- dmem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00}).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  XLEN  lane-replicated store data.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  XLEN  read data.

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset state: IDLE, m_ready=1, wb_valid=0, wb_pc=RESET_PC, wb_rd=0, wb_data=0, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_be=0, dmem_wdata=0.
- FSM states: IDLE, REQ, WAIT. m_ready=1 only in IDLE. Inputs are sampled only when m_valid && m_ready.
- IDLE:
  - Non-memory op: next cycle wb_valid=1, wb_data=alu_result, wb_rd=rd_in, wb_pc=m_pc; state stays IDLE (1-cycle latency, back-to-back accepted).
  - is_load or is_store: latch pc, rd, funct3, address, store data; next state REQ.
  - is_load and is_store both set: treated as a store.
- REQ:
  - dmem_req=1. dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and held stable until dmem_gnt=1.
  - On gnt with a store: next cycle wb_valid=1, wb_rd=0, wb_data=0; state goes to IDLE.
  - On gnt with a load: state goes to WAIT.
  - dmem_req drops the cycle after gnt.
- WAIT:
  - dmem_rvalid is not expected before the cycle after gnt.
  - On rvalid: next cycle wb_valid=1, wb_data=extracted value, wb_rd=latched rd; state goes to IDLE.
- Minimum latency, accept to wb_valid: store 2 cycles, load 3 cycles.
- Stores:
  - SB (000): be=4'b0001<<addr[1:0], wdata={4{byte}}.
  - SH (001): be=addr[1]?4'b1100:4'b0011, wdata={2{half}}.
  - SW (010): be=4'b1111.
- Loads:
  - LB (000) sign-extends the byte at addr[1:0]; LBU (100) zero-extends it.
  - LH (001) sign-extends the half selected by addr[1]; LHU (101) zero-extends it.
  - LW (010) returns the full word.
- Reserved funct3 (011, 110, 111): treated as word access.
- Misalignment without the optional feature: addr[0] is ignored for halves; addr[1:0] is ignored for words.
- dmem_rvalid/dmem_gnt seen in IDLE: ignored.
- Reset mid-access (REQ or WAIT): returns to IDLE. dmem_req=0 from the next cycle. No wb_valid is produced for the aborted op. A late rvalid is ignored.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign_exc (1 bit).
  - In IDLE, a half access with addr[0]=1 or a word access with addr[1:0]!=0 does not enter REQ and issues no memory request.
  - Next cycle: wb_valid=1, misalign_exc=1, wb_data=address, wb_rd=0.
  - misalign_exc is 0 at reset and otherwise.
- When undefined: no port; misaligned accesses behave as above.

Test Plan:
- ALU op alu_result=32'h0000_1234, rd_in=5, m_pc=32'h40 -> next cycle wb_valid=1, wb_data=32'h1234, wb_rd=5, wb_pc=32'h40, m_ready stays 1.
- SB addr=32'h1003, store_data=32'hAB, gnt same cycle as req -> dmem_addr=32'h1000, be=4'b1000, wdata=32'hABABABAB, wb_valid 2 cycles after accept, wb_rd=0.
- LB addr=32'h2002, rdata=32'h0080_0000, rvalid 3 cycles after gnt -> wb_data=32'hFFFF_FF80. LBU with the same stimulus -> 32'h0000_0080. m_ready=0 throughout.
- LH with gnt withheld 4 cycles -> dmem_req, dmem_addr, dmem_be stable all 4 cycles, req drops after gnt, single wb_valid pulse.
- Reset asserted in WAIT, then rvalid -> no wb_valid, state IDLE, m_ready=1, all outputs at reset values.
- MEM_MISALIGN_TRAP_EN defined, LW addr=32'h0000_0006 -> dmem_req never asserted, next cycle misalign_exc=1, wb_data=32'h6.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage after execute. ALU results pass straight to writeback.
// Loads and stores run a req/gnt/rvalid handshake to data memory. Load data is aligned and extended here.
//   clock/reset           : stage clock; synchronous active-high reset
//   m_valid/m_ready       : handshake with the execute stage (m_pc, is_load, is_store, funct3, alu_result, store_data, rd_in)
//   wb_*                  : one-cycle completion pulse with pc, destination and writeback value
//   dmem_*                : data-memory request (req/we/addr/be/wdata) and response (gnt/rvalid/rdata)
//   misalign_exc          : only when MEM_MISALIGN_TRAP_EN is defined; flags a trapped misaligned access
module mem_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            m_valid,
    input  logic [XLEN-1:0] m_pc,
    input  logic            is_load,
    input  logic            is_store,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [4:0]      rd_in,
    output logic            m_ready,
    output logic            wb_valid,
    output logic [XLEN-1:0] wb_pc,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic            misalign_exc,
`endif
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
    state_t state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, daddr_q, daddr_d, wdata_q, wdata_d, wbpc_q, wbpc_d, wbdata_q, wbdata_d;
    logic [4:0] rd_q, rd_d, wbrd_q, wbrd_d;
    logic [2:0] f3_q, f3_d;
    logic [1:0] off_q, off_d;
    logic [3:0] be_q, be_d;
    logic st_q, st_d, req_q, req_d, we_q, we_d, wbv_q, wbv_d, mis_q, mis_d;
    logic acc, mem, mis;
    logic [1:0] sz;
    logic [7:0] lbyte;
    logic [15:0] lhalf;
    logic [XLEN-1:0] ld;
    assign acc = m_valid && state_q == S_IDLE;
    assign mem = is_load || is_store;
    // funct3[1:0] gives the access size; reserved codes (x11, 110) fall through to word
    assign sz  = funct3[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
    assign mis = (sz == 2'b01 && alu_result[0]) || (sz[1] && alu_result[1:0] != 2'b00);
    assign misalign_exc = mis_q;
`else
    assign mis = 1'b0;
`endif
    assign lbyte = off_q == 2'd0 ? dmem_rdata[7:0] : off_q == 2'd1 ? dmem_rdata[15:8] :
                   off_q == 2'd2 ? dmem_rdata[23:16] : dmem_rdata[31:24];
    assign lhalf = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    assign ld = f3_q[1:0] == 2'b00 ? {{24{~f3_q[2] & lbyte[7]}}, lbyte} :
                f3_q[1:0] == 2'b01 ? {{16{~f3_q[2] & lhalf[15]}}, lhalf} : dmem_rdata;
    always_ff @(posedge clock) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end
    always_comb begin
        state_d = state_q == S_IDLE ? ((acc && mem && !mis) ? S_REQ : S_IDLE) :
                  state_q == S_REQ  ? (dmem_gnt ? (st_q ? S_IDLE : S_WAIT) : S_REQ) :
                  (dmem_rvalid ? S_IDLE : S_WAIT);
    end
    always_comb begin
        m_ready = state_q == S_IDLE;
    end
    always_comb begin
        pc_d = pc_q;
        rd_d = rd_q;
        f3_d = f3_q;
        off_d = off_q;
        st_d = st_q;
        req_d = req_q;
        we_d = we_q;
        daddr_d = daddr_q;
        be_d = be_q;
        wdata_d = wdata_q;
        wbv_d = 1'b0;
        mis_d = 1'b0;
        wbpc_d = wbpc_q;
        wbrd_d = wbrd_q;
        wbdata_d = wbdata_q;
        if (acc && !mem) begin
            wbv_d = 1'b1;
            wbpc_d = m_pc;
            wbrd_d = rd_in;
            wbdata_d = alu_result;
        end
        if (acc && mem && mis) begin
            wbv_d = 1'b1;
            mis_d = 1'b1;
            wbpc_d = m_pc;
            wbrd_d = 5'd0;
            wbdata_d = alu_result;
        end
        if (acc && mem && !mis) begin
            pc_d = m_pc;
            rd_d = rd_in;
            f3_d = funct3;
            off_d = alu_result[1:0];
            st_d = is_store;
            req_d = 1'b1;
            we_d = is_store;
            daddr_d = {alu_result[XLEN-1:2], 2'b00};
            be_d = sz == 2'b00 ? 4'b0001 << alu_result[1:0] :
                   sz == 2'b01 ? (alu_result[1] ? 4'b1100 : 4'b0011) : 4'b1111;
            wdata_d = sz == 2'b00 ? {4{store_data[7:0]}} :
                      sz == 2'b01 ? {2{store_data[15:0]}} : store_data;
        end
        if (state_q == S_REQ && dmem_gnt) begin
            req_d = 1'b0;
            if (st_q) begin
                wbv_d = 1'b1;
                wbpc_d = pc_q;
                wbrd_d = 5'd0;
                wbdata_d = '0;
            end
        end
        if (state_q == S_WAIT && dmem_rvalid) begin
            wbv_d = 1'b1;
            wbpc_d = pc_q;
            wbrd_d = rd_q;
            wbdata_d = ld;
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= '0;
            rd_q <= '0;
            f3_q <= '0;
            off_q <= '0;
            st_q <= 1'b0;
            req_q <= 1'b0;
            we_q <= 1'b0;
            daddr_q <= '0;
            be_q <= '0;
            wdata_q <= '0;
            wbv_q <= 1'b0;
            mis_q <= 1'b0;
            wbpc_q <= RESET_PC;
            wbrd_q <= '0;
            wbdata_q <= '0;
        end else begin
            pc_q <= pc_d;
            rd_q <= rd_d;
            f3_q <= f3_d;
            off_q <= off_d;
            st_q <= st_d;
            req_q <= req_d;
            we_q <= we_d;
            daddr_q <= daddr_d;
            be_q <= be_d;
            wdata_q <= wdata_d;
            wbv_q <= wbv_d;
            mis_q <= mis_d;
            wbpc_q <= wbpc_d;
            wbrd_q <= wbrd_d;
            wbdata_q <= wbdata_d;
        end
    end
    assign wb_valid = wbv_q;
    assign wb_pc = wbpc_q;
    assign wb_rd = wbrd_q;
    assign wb_data = wbdata_q;
    assign dmem_req = req_q;
    assign dmem_we = we_q;
    assign dmem_addr = daddr_q;
    assign dmem_be = be_q;
    assign dmem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed self-checking bench for mem_stage
module tb_mem_stage;
    localparam logic [31:0] RPC = 32'h0000_0100;
    logic clock = 1'b0, reset = 1'b1;
    logic m_valid = 1'b0, is_load = 1'b0, is_store = 1'b0;
    logic [31:0] m_pc = '0, alu_result = '0, store_data = '0, dmem_rdata = '0;
    logic [2:0] funct3 = '0;
    logic [4:0] rd_in = '0;
    logic dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
    logic m_ready, wb_valid, dmem_req, dmem_we;
    logic [31:0] wb_pc, wb_data, dmem_addr, dmem_wdata;
    logic [4:0] wb_rd;
    logic [3:0] dmem_be;
`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_exc;
`endif
    int n_cmp = 0, n_err = 0;

    mem_stage #(.XLEN(32), .RESET_PC(RPC)) dut (
        .clock(clock), .reset(reset), .m_valid(m_valid), .m_pc(m_pc),
        .is_load(is_load), .is_store(is_store), .funct3(funct3),
        .alu_result(alu_result), .store_data(store_data), .rd_in(rd_in),
        .m_ready(m_ready), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_rd(wb_rd),
        .wb_data(wb_data), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign_exc(misalign_exc),
`endif
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, ".m_ready"}, m_ready, 1);
        check({tag, ".wb_valid"}, wb_valid, 0);
        check({tag, ".wb_pc"}, wb_pc, RPC);
        check({tag, ".wb_rd"}, wb_rd, 0);
        check({tag, ".wb_data"}, wb_data, 0);
        check({tag, ".req"}, dmem_req, 0);
        check({tag, ".we"}, dmem_we, 0);
        check({tag, ".addr"}, dmem_addr, 0);
        check({tag, ".be"}, dmem_be, 0);
        check({tag, ".wdata"}, dmem_wdata, 0);
    endtask

    task automatic alu_op(input string tag, input logic [31:0] res, input logic [4:0] rd, input logic [31:0] pc);
        m_valid = 1'b1; is_load = 1'b0; is_store = 1'b0;
        alu_result = res; rd_in = rd; m_pc = pc;
        check({tag, ".ready_in"}, m_ready, 1);
        tick;
        check({tag, ".wb_valid"}, wb_valid, 1);
        check({tag, ".wb_data"}, wb_data, res);
        check({tag, ".wb_rd"}, wb_rd, rd);
        check({tag, ".wb_pc"}, wb_pc, pc);
        check({tag, ".ready"}, m_ready, 1);
        check({tag, ".req"}, dmem_req, 0);
    endtask

    // gd: cycles gnt is withheld; rvd: idle cycles in WAIT before rvalid
    task automatic mem_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] rd,
                          input logic [31:0] pc, input int gd, input int rvd, input logic [31:0] rdata,
                          input logic [31:0] e_addr, input logic [3:0] e_be, input logic [31:0] e_wd,
                          input logic [31:0] e_data);
        m_valid = 1'b1; is_load = ld; is_store = st; funct3 = f3;
        alu_result = addr; store_data = sd; rd_in = rd; m_pc = pc;
        tick;
        m_valid = 1'b0; is_load = 1'b0; is_store = 1'b0; alu_result = '0; store_data = '0;
        for (int i = 0; i <= gd; i++) begin
            check({tag, ".req"}, dmem_req, 1);
            check({tag, ".we"}, dmem_we, st);
            check({tag, ".addr"}, dmem_addr, e_addr);
            check({tag, ".be"}, dmem_be, e_be);
            if (st) check({tag, ".wdata"}, dmem_wdata, e_wd);
            check({tag, ".ready"}, m_ready, 0);
            check({tag, ".wb_early"}, wb_valid, 0);
            dmem_gnt = (i == gd);
            tick;
        end
        dmem_gnt = 1'b0;
        check({tag, ".req_drop"}, dmem_req, 0);
        if (!st) begin
            for (int i = 0; i <= rvd; i++) begin
                check({tag, ".wait_wb"}, wb_valid, 0);
                check({tag, ".wait_ready"}, m_ready, 0);
                dmem_rvalid = (i == rvd);
                dmem_rdata = (i == rvd) ? rdata : 32'h5A5A_5A5A;
                tick;
            end
            dmem_rvalid = 1'b0; dmem_rdata = '0;
        end
        check({tag, ".wb_valid"}, wb_valid, 1);
        check({tag, ".wb_data"}, wb_data, e_data);
        check({tag, ".wb_rd"}, wb_rd, st ? 5'd0 : rd);
        check({tag, ".wb_pc"}, wb_pc, pc);
        check({tag, ".ready_back"}, m_ready, 1);
        tick;
        check({tag, ".wb_pulse"}, wb_valid, 0);
    endtask

    initial begin
        tick;
        tick;
        check_reset_outs("rst");
        reset = 1'b0;
        tick;
        check_reset_outs("post_rst");
        alu_op("alu0", 32'h0000_1234, 5'd5, 32'h40);
        alu_op("alu1", 32'hFFFF_0001, 5'd31, 32'h44);
        m_valid = 1'b0;
        tick;
        check("alu_pulse", wb_valid, 0);
        mem_op("sb", 0, 1, 3'b000, 32'h1003, 32'h0000_00AB, 5'd7, 32'h48, 0, 0, 0, 32'h1000, 4'b1000, 32'hABAB_ABAB, 0);
        mem_op("sh", 0, 1, 3'b001, 32'h1002, 32'h1111_BEEF, 5'd7, 32'h4C, 1, 0, 0, 32'h1000, 4'b1100, 32'hBEEF_BEEF, 0);
        mem_op("sw", 0, 1, 3'b010, 32'h1004, 32'h1234_5678, 5'd7, 32'h50, 0, 0, 0, 32'h1004, 4'b1111, 32'h1234_5678, 0);
        mem_op("ldst", 1, 1, 3'b010, 32'h100C, 32'hCAFE_F00D, 5'd8, 32'h54, 0, 0, 0, 32'h100C, 4'b1111, 32'hCAFE_F00D, 0);
        mem_op("lb", 1, 0, 3'b000, 32'h2002, 0, 5'd9, 32'h58, 0, 2, 32'h0080_0000, 32'h2000, 4'b0100, 0, 32'hFFFF_FF80);
        mem_op("lbu", 1, 0, 3'b100, 32'h2002, 0, 5'd9, 32'h5C, 0, 2, 32'h0080_0000, 32'h2000, 4'b0100, 0, 32'h0000_0080);
        mem_op("lh", 1, 0, 3'b001, 32'h2006, 0, 5'd10, 32'h60, 4, 0, 32'h8001_1234, 32'h2004, 4'b1100, 0, 32'hFFFF_8001);
        mem_op("lhu", 1, 0, 3'b101, 32'h2004, 0, 5'd11, 32'h64, 0, 1, 32'h8001_9234, 32'h2004, 4'b0011, 0, 32'h0000_9234);
        mem_op("lw", 1, 0, 3'b010, 32'h3008, 0, 5'd12, 32'h68, 2, 0, 32'hDEAD_BEEF, 32'h3008, 4'b1111, 0, 32'hDEAD_BEEF);
        mem_op("lrsv", 1, 0, 3'b011, 32'h300C, 0, 5'd13, 32'h6C, 0, 0, 32'h8765_4321, 32'h300C, 4'b1111, 0, 32'h8765_4321);
`ifndef MEM_MISALIGN_TRAP_EN
        mem_op("lh_mis", 1, 0, 3'b001, 32'h2003, 0, 5'd14, 32'h70, 0, 0, 32'hAAAA_5555, 32'h2000, 4'b1100, 0, 32'hFFFF_AAAA);
        mem_op("lw_mis", 1, 0, 3'b010, 32'h0006, 0, 5'd15, 32'h74, 0, 0, 32'h0102_0304, 32'h0004, 4'b1111, 0, 32'h0102_0304);
`else
        m_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; alu_result = 32'h6; rd_in = 5'd3; m_pc = 32'h80;
        check("trap.req0", dmem_req, 0);
        tick;
        m_valid = 1'b0; is_load = 1'b0;
        check("trap.req", dmem_req, 0);
        check("trap.wb_valid", wb_valid, 1);
        check("trap.exc", misalign_exc, 1);
        check("trap.wb_data", wb_data, 32'h6);
        check("trap.wb_rd", wb_rd, 0);
        check("trap.ready", m_ready, 1);
        tick;
        check("trap.exc_clr", misalign_exc, 0);
        check("trap.req_later", dmem_req, 0);
`endif
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
        tick;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        check("idle_ign.wb", wb_valid, 0);
        check("idle_ign.req", dmem_req, 0);
        check("idle_ign.ready", m_ready, 1);
        m_valid = 1'b1; is_load = 1'b1; funct3 = 3'b010; alu_result = 32'h4000; rd_in = 5'd6; m_pc = 32'h90;
        tick;
        m_valid = 1'b0; is_load = 1'b0;
        check("abort.req", dmem_req, 1);
        dmem_gnt = 1'b1;
        tick;
        dmem_gnt = 1'b0;
        check("abort.wait", m_ready, 0);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        check_reset_outs("abort_rst");
        dmem_rvalid = 1'b1; dmem_rdata = 32'h2468_ACE0;
        tick;
        dmem_rvalid = 1'b0;
        check_reset_outs("late_rv");
        tick;
        check("late_rv2.wb", wb_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
